pdua_datapath: RTL and testbench

//   8-bit datapath of the PDUA teaching processor. Contains a register bank, an ALU with a

---
 rtl/pdua_datapath.sv | 229 ++++++++++++++++++++++
 tb/tb_pdua_datapath.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdua_datapath.sv
// pdua_datapath: 8-bit datapath of the PDUA teaching processor.
// Register bank (PC, SP, DPTR, A, VI, TEMP, CTE1, ACC), ALU with post-shifter and
// registered C/N/P/Z flags, MAR/MDR/IR and an internal RAM addressed by MAR.
// Sequenced cycle-by-cycle by an external control unit.
//
// RAM starts all zeros.
module pdua_datapath #(
   parameter int MAX_WIDTH  = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_rdn,
   input  logic                  enaf,
   input  logic [2:0]            selop,
   input  logic [1:0]            shamt,
   output logic                  C,
   output logic                  N,
   output logic                  P,
   output logic                  Z,
   input  logic                  bank_wr_en,
   input  logic [ADDR_WIDTH-1:0] BusB_addr,
   input  logic [ADDR_WIDTH-1:0] BusC_addr,
   input  logic                  sclr,
   input  logic                  ir_en,
   input  logic                  mar_en,
   input  logic                  mdr_en,
   input  logic                  mdr_alu_n,
   output logic [4:0]            out_IR
);

   localparam int NREG  = 2**ADDR_WIDTH;
   localparam int DEPTH = 2**MAX_WIDTH;

   localparam logic [ADDR_WIDTH-1:0] ADDR_CTE1 = ADDR_WIDTH'(6);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ACC  = ADDR_WIDTH'(7);

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_NOTB = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_INC  = 3'b110;
   localparam logic [2:0] OP_DEC  = 3'b111;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_SHL  = 2'b01;
   localparam logic [1:0] SH_SHR  = 2'b10;
   localparam logic [1:0] SH_ROR  = 2'b11;

   // Architectural state
   logic [MAX_WIDTH-1:0] bank_q [NREG];
   logic [MAX_WIDTH-1:0] bank_d [NREG];
   logic [MAX_WIDTH-1:0] mar_q, mar_d;
   logic [MAX_WIDTH-1:0] mdr_q, mdr_d;
   logic [MAX_WIDTH-1:0] ir_q, ir_d;
   logic                 c_q, c_d;
   logic                 n_q, n_d;
   logic                 p_q, p_d;
   logic                 z_q, z_d;

   // Datapath nets
   logic [MAX_WIDTH-1:0] bus_a;
   logic [MAX_WIDTH-1:0] bus_b;
   logic [MAX_WIDTH-1:0] bus_c;
   logic [MAX_WIDTH:0]   alu_sum;
   logic [MAX_WIDTH-1:0] alu_r;
   logic                 alu_c;
   logic [MAX_WIDTH-1:0] shf_y;
   logic                 shf_c;
   logic [MAX_WIDTH-1:0] ram_rd;
   logic                 ram_we;

   logic [MAX_WIDTH-1:0] ram_q [DEPTH] = '{default: '0};

   // Operand fetch: A is always ACC; CTE1 is a hard-wired constant 1, not storage.
   always_comb begin
      bus_a = bank_q[ADDR_ACC];
      if (BusB_addr == ADDR_CTE1) begin
         bus_b = MAX_WIDTH'(1);
      end else begin
         bus_b = bank_q[BusB_addr];
      end
   end

   // ALU: arithmetic ops share one (MAX_WIDTH+1)-bit adder so the carry is its top bit.
   always_comb begin
      alu_sum = '0;
      alu_r   = '0;
      alu_c   = 1'b0;
      case (selop)
         OP_PASS: alu_r = bus_b;
         OP_AND:  alu_r = bus_a & bus_b;
         OP_OR:   alu_r = bus_a | bus_b;
         OP_NOTB: alu_r = ~bus_b;
         OP_ADD:  alu_sum = {1'b0, bus_a} + {1'b0, bus_b};
         OP_SUB:  alu_sum = {1'b0, bus_a} + {1'b0, ~bus_b} + (MAX_WIDTH+1)'(1);
         OP_INC:  alu_sum = {1'b0, bus_b} + (MAX_WIDTH+1)'(1);
         OP_DEC:  alu_sum = {1'b0, bus_b} + {1'b0, {MAX_WIDTH{1'b1}}};
         default: alu_r = bus_b;
      endcase
      // Adding all-ones for B-1 yields carry = (B != 0) for free.
      if (selop[2]) begin
         alu_r = alu_sum[MAX_WIDTH-1:0];
         alu_c = alu_sum[MAX_WIDTH];
      end
   end

   // Post-shifter: any real shift replaces the ALU carry with the bit shifted out.
   always_comb begin
      shf_y = alu_r;
      shf_c = alu_c;
      case (shamt)
         SH_NONE: begin
            shf_y = alu_r;
            shf_c = alu_c;
         end
         SH_SHL: begin
            shf_y = {alu_r[MAX_WIDTH-2:0], 1'b0};
            shf_c = alu_r[MAX_WIDTH-1];
         end
         SH_SHR: begin
            shf_y = {1'b0, alu_r[MAX_WIDTH-1:1]};
            shf_c = alu_r[0];
         end
         SH_ROR: begin
            shf_y = {alu_r[0], alu_r[MAX_WIDTH-1:1]};
            shf_c = alu_r[0];
         end
         default: begin
            shf_y = alu_r;
            shf_c = alu_c;
         end
      endcase
   end

   // BusC source select and asynchronous RAM read port.
   always_comb begin
      bus_c  = mdr_alu_n ? mdr_q : shf_y;
      ram_rd = ram_q[mar_q];
   end

   // Bank write-back; CTE1 slot is never written.
   always_comb begin
      bank_d = bank_q;
      if (bank_wr_en && (BusC_addr != ADDR_CTE1)) begin
         bank_d[BusC_addr] = bus_c;
      end
   end

   // MAR/MDR/IR/flags next state; sclr overrides every load enable.
   always_comb begin
      mar_d = mar_q;
      mdr_d = mdr_q;
      ir_d  = ir_q;
      c_d   = c_q;
      n_d   = n_q;
      p_d   = p_q;
      z_d   = z_q;
      if (sclr) begin
         mar_d = '0;
         mdr_d = '0;
         ir_d  = '0;
         c_d   = 1'b0;
         n_d   = 1'b0;
         p_d   = 1'b0;
         z_d   = 1'b0;
      end else begin
         if (mar_en) begin
            mar_d = shf_y;
         end
         if (mdr_en) begin
            mdr_d = wr_rdn ? shf_y : ram_rd;
         end
         if (ir_en) begin
            ir_d = mdr_q;
         end
         if (enaf) begin
            c_d = shf_c;
            n_d = shf_y[MAX_WIDTH-1];
            z_d = (shf_y == '0);
            p_d = ^shf_y;
         end
      end
   end

   // Register update with synchronous active-low reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            bank_q[i] <= '0;
         end
         mar_q <= '0;
         mdr_q <= '0;
         ir_q  <= '0;
         c_q   <= 1'b0;
         n_q   <= 1'b0;
         p_q   <= 1'b0;
         z_q   <= 1'b0;
      end else begin
         bank_q <= bank_d;
         mar_q  <= mar_d;
         mdr_q  <= mdr_d;
         ir_q   <= ir_d;
         c_q    <= c_d;
         n_q    <= n_d;
         p_q    <= p_d;
         z_q    <= z_d;
      end
   end

   // RAM store uses pre-edge MAR/MDR; a cycle in reset never stores.
   assign ram_we = rst & wr_rdn & ~mdr_en;

   // RAM write port (contents are not reset).
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[mar_q] <= mdr_q;
      end
   end

   assign C      = c_q;
   assign N      = n_q;
   assign P      = p_q;
   assign Z      = z_q;
   assign out_IR = ir_q[MAX_WIDTH-1 -: 5];

endmodule

// File: tb/tb_pdua_datapath.sv
// tb_pdua_datapath: scoreboard bench for pdua_datapath (default build, RAM starts zero).
module tb_pdua_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_rdn;
   logic       enaf;
   logic [2:0] selop;
   logic [1:0] shamt;
   logic       C, N, P, Z;
   logic       bank_wr_en;
   logic [2:0] BusB_addr;
   logic [2:0] BusC_addr;
   logic       sclr;
   logic       ir_en;
   logic       mar_en;
   logic       mdr_en;
   logic       mdr_alu_n;
   logic [4:0] out_IR;

   pdua_datapath dut (
      .clk        (clk),
      .rst        (rst),
      .wr_rdn     (wr_rdn),
      .enaf       (enaf),
      .selop      (selop),
      .shamt      (shamt),
      .C          (C),
      .N          (N),
      .P          (P),
      .Z          (Z),
      .bank_wr_en (bank_wr_en),
      .BusB_addr  (BusB_addr),
      .BusC_addr  (BusC_addr),
      .sclr       (sclr),
      .ir_en      (ir_en),
      .mar_en     (mar_en),
      .mdr_en     (mdr_en),
      .mdr_alu_n  (mdr_alu_n),
      .out_IR     (out_IR)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   logic [7:0] m_bank [8];
   logic [7:0] m_ram  [256];
   logic [7:0] m_mar, m_mdr, m_ir;
   logic [3:0] m_flags;   // {C,N,P,Z}

   typedef struct packed {
      logic [3:0]      flags;
      logic [4:0]      ir_op;
      logic [7:0]      mar;
      logic [7:0]      mdr;
      logic [7:0][7:0] bank;
   } exp_t;

   exp_t sb_q[$];

   // Advance the model by one clock edge using the currently driven inputs, queue the result.
   task automatic model_edge();
      int   a, b, r, s, c, y, yc, ones;
      logic [7:0] busc, old_mdr, old_mar;
      exp_t e;
      a = int'(m_bank[7]);
      b = (BusB_addr == 3'd6) ? 1 : int'(m_bank[BusB_addr]);
      c = 0;
      r = 0;
      case (selop)
         3'd0: r = b;
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = 255 - b;
         3'd4: begin s = a + b; r = s % 256; c = (s > 255) ? 1 : 0; end
         3'd5: begin r = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
         3'd6: begin r = (b + 1) % 256; c = (b == 255) ? 1 : 0; end
         default: begin r = (b == 0) ? 255 : b - 1; c = (b != 0) ? 1 : 0; end
      endcase
      case (shamt)
         2'd1: begin y = (r * 2) % 256; yc = r / 128; end
         2'd2: begin y = r / 2; yc = r % 2; end
         2'd3: begin y = r / 2 + (r % 2) * 128; yc = r % 2; end
         default: begin y = r; yc = c; end
      endcase
      ones = 0;
      for (int i = 0; i < 8; i++) ones += (y >> i) & 1;

      old_mdr = m_mdr;
      old_mar = m_mar;
      if (rst == 1'b0) begin
         for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
         m_mar = 8'h00;
         m_mdr = 8'h00;
         m_ir = 8'h00;
         m_flags = 4'h0;
      end else begin
         if (wr_rdn && !mdr_en) m_ram[old_mar] = old_mdr;
         busc = mdr_alu_n ? old_mdr : 8'(y);
         if (bank_wr_en && BusC_addr != 3'd6) m_bank[BusC_addr] = busc;
         if (sclr) begin
            m_mar = 8'h00;
            m_mdr = 8'h00;
            m_ir = 8'h00;
            m_flags = 4'h0;
         end else begin
            if (ir_en) m_ir = old_mdr;
            if (mdr_en) m_mdr = wr_rdn ? 8'(y) : m_ram[old_mar];
            if (mar_en) m_mar = 8'(y);
            if (enaf) m_flags = {yc[0], (y >= 128), ones[0], (y == 0)};
         end
      end
      e.flags = m_flags;
      e.ir_op = m_ir[7:3];
      e.mar   = m_mar;
      e.mdr   = m_mdr;
      for (int i = 0; i < 8; i++) e.bank[i] = m_bank[i];
      sb_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      e = sb_q.pop_front();
      check_eq("flags", 32'({C, N, P, Z}), 32'(e.flags));
      check_eq("out_IR", 32'(out_IR), 32'(e.ir_op));
      check_eq("mar", 32'(dut.mar_q), 32'(e.mar));
      check_eq("mdr", 32'(dut.mdr_q), 32'(e.mdr));
      for (int k = 0; k < 8; k++) begin
         if (k != 6) check_eq($sformatf("bank%0d", k), 32'(dut.bank_q[k]), 32'(e.bank[k]));
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_out();
   endtask

   task automatic idle();
      rst        = 1'b1;
      wr_rdn     = 1'b0;
      enaf       = 1'b0;
      selop      = 3'd0;
      shamt      = 2'd0;
      bank_wr_en = 1'b0;
      BusB_addr  = 3'd0;
      BusC_addr  = 3'd0;
      sclr       = 1'b0;
      ir_en      = 1'b0;
      mar_en     = 1'b0;
      mdr_en     = 1'b0;
      mdr_alu_n  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;
      for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
      m_mar = 8'h00; m_mdr = 8'h00; m_ir = 8'h00; m_flags = 4'h0;
      idle();
      @(negedge clk);

      // 1. reset and combinational bank read
      rst = 1'b0;
      step();
      check_eq("t1_flags", 32'({C, N, P, Z}), 32'h0);
      check_eq("t1_out_IR", 32'(out_IR), 32'h0);
      for (int k = 0; k < 8; k++) begin
         idle(); selop = 3'd0; enaf = 1'b1; BusB_addr = 3'(k);
         step();
         check_eq($sformatf("t1_z_busb%0d", k), 32'(Z), (k == 6) ? 32'd0 : 32'd1);
         check_eq($sformatf("t1_p_busb%0d", k), 32'(P), (k == 6) ? 32'd1 : 32'd0);
      end

      // 2. load ACC from CTE1
      idle(); BusB_addr = 3'd6; BusC_addr = 3'd7; bank_wr_en = 1'b1; enaf = 1'b1;
      step();
      check_eq("t2_acc", 32'(dut.bank_q[7]), 32'd1);
      check_eq("t2_flags", 32'({C, N, P, Z}), 32'b0010);

      // 3. mov dptr,acc with MAR load
      idle(); BusB_addr = 3'd7; BusC_addr = 3'd2; bank_wr_en = 1'b1; mar_en = 1'b1;
      step();
      check_eq("t3_dptr", 32'(dut.bank_q[2]), 32'd1);
      check_eq("t3_mar", 32'(dut.mar_q), 32'd1);

      // 4. shift ACC left three times, then ACC-ACC with write attempt to CTE1
      for (int i = 0; i < 3; i++) begin
         idle(); BusB_addr = 3'd7; shamt = 2'd1; BusC_addr = 3'd7; bank_wr_en = 1'b1;
         step();
      end
      check_eq("t4_acc", 32'(dut.bank_q[7]), 32'h08);
      idle(); selop = 3'd5; BusB_addr = 3'd7; enaf = 1'b1; BusC_addr = 3'd6; bank_wr_en = 1'b1;
      step();
      check_eq("t4_flags", 32'({C, N, P, Z}), 32'b1001);
      idle(); selop = 3'd0; BusB_addr = 3'd6; enaf = 1'b1;
      step();
      check_eq("t4_cte1_p", 32'(P), 32'd1);

      // 5. RAM store/load and IR
      idle(); mdr_en = 1'b1; wr_rdn = 1'b1; BusB_addr = 3'd7;
      step();
      check_eq("t5_mdr_alu", 32'(dut.mdr_q), 32'h08);
      idle(); wr_rdn = 1'b1;
      step();
      check_eq("t5_ram1", 32'(dut.ram_q[1]), 32'h08);
      idle(); sclr = 1'b1;
      step();
      check_eq("t5_mdr_sclr", 32'(dut.mdr_q), 32'h00);
      idle(); BusB_addr = 3'd6; mar_en = 1'b1;
      step();
      idle(); mdr_en = 1'b1;
      step();
      check_eq("t5_mdr_ram", 32'(dut.mdr_q), 32'h08);
      idle(); ir_en = 1'b1;
      step();
      check_eq("t5_out_IR", 32'(out_IR), 32'b00001);

      // 6. reset beats every enable; sclr beats ir_en
      idle(); rst = 1'b0; bank_wr_en = 1'b1; mar_en = 1'b1; enaf = 1'b1;
      BusB_addr = 3'd6; BusC_addr = 3'd7;
      step();
      check_eq("t6_acc", 32'(dut.bank_q[7]), 32'h00);
      check_eq("t6_dptr", 32'(dut.bank_q[2]), 32'h00);
      check_eq("t6_mar", 32'(dut.mar_q), 32'h00);
      check_eq("t6_flags", 32'({C, N, P, Z}), 32'h0);
      idle(); BusB_addr = 3'd6; mar_en = 1'b1;
      step();
      idle(); mdr_en = 1'b1;
      step();
      idle(); ir_en = 1'b1;
      step();
      check_eq("t6_ir_loaded", 32'(out_IR), 32'b00001);
      idle(); sclr = 1'b1; ir_en = 1'b1;
      step();
      check_eq("t6_ir_sclr", 32'(out_IR), 32'h0);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 39) != 0);
         sclr       = ($urandom_range(0, 15) == 0);
         wr_rdn     = 1'($urandom_range(0, 1));
         enaf       = 1'($urandom_range(0, 1));
         selop      = 3'($urandom_range(0, 7));
         shamt      = 2'($urandom_range(0, 3));
         bank_wr_en = 1'($urandom_range(0, 1));
         BusB_addr  = 3'($urandom_range(0, 7));
         BusC_addr  = 3'($urandom_range(0, 7));
         ir_en      = 1'($urandom_range(0, 1));
         mar_en     = 1'($urandom_range(0, 1));
         mdr_en     = 1'($urandom_range(0, 1));
         mdr_alu_n  = 1'($urandom_range(0, 1));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
